// File: rtl/qcv_pkg.sv
// Shared definitions for the qcv multiply/divide unit: operator codes (RV32M funct3),
// FSM state encoding and small operator-decoding helpers.
package qcv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    function automatic logic md_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic md_is_rem(input logic [2:0] op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // MULHSU treats rs1 as signed but rs2 as unsigned, hence separate helpers
    function automatic logic md_a_signed(input logic [2:0] op);
        return !((op == MD_MULHU) || (op == MD_DIVU) || (op == MD_REMU));
    endfunction

    function automatic logic md_b_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/qcv_muldiv_fixup.sv
// Combinational sign correction and high/low word selection applied to the
// magnitude result held in the multiply/divide accumulator.
module qcv_muldiv_fixup
    import qcv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]         op_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               neg_res_i,
    input  logic               neg_rem_i,
    input  logic               bypass_i,
    output logic [WIDTH-1:0]   result_o
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // The accumulator holds {remainder, quotient} for divides and the full product for multiplies
    always_comb begin
        prod     = neg_res_i ? -acc_i : acc_i;
        quo      = neg_res_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem      = neg_rem_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        result_o = '0;
        if (bypass_i) begin
            result_o = acc_i[WIDTH-1:0];
        end else begin
            case (op_i)
                MD_MUL:                       result_o = prod[WIDTH-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod[2*WIDTH-1:WIDTH];
                MD_DIV, MD_DIVU:              result_o = quo;
                default:                      result_o = rem;
            endcase
        end
    end

endmodule

// File: rtl/qcv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// with single-cycle fast path for divide-by-zero and signed overflow.
module qcv_muldiv
    import qcv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       operator_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               fast_q, fast_d;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_by_zero, div_overflow;
    logic [WIDTH-1:0]   fast_val;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next;
    logic [WIDTH-1:0]   fix_result;

    // Operand decode at accept time: magnitudes, sign flags and special divide cases
    always_comb begin
        neg_a        = md_a_signed(operator_i) & operand_a_i[WIDTH-1];
        neg_b        = md_b_signed(operator_i) & operand_b_i[WIDTH-1];
        mag_a        = neg_a ? -operand_a_i : operand_a_i;
        mag_b        = neg_b ? -operand_b_i : operand_b_i;
        div_by_zero  = md_is_div(operator_i) && (operand_b_i == '0);
        div_overflow = md_is_div(operator_i) && md_b_signed(operator_i)
                       && (operand_a_i == {1'b1, {(WIDTH-1){1'b0}}})
                       && (operand_b_i == '1);
        fast_val     = '0;
        if (div_by_zero) begin
            fast_val = md_is_rem(operator_i) ? operand_a_i : '1;
        end else if (div_overflow) begin
            fast_val = md_is_rem(operator_i) ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // One iteration of each algorithm; the remainder never exceeds the divisor so WIDTH bits hold it
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_trial = rem_shift - {1'b0, mcand_q};
        if (div_trial[WIDTH]) begin
            div_next = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        fast_d    = fast_q;
        case (state_q)
            MD_IDLE: begin
                if (valid_i) begin
                    op_d      = operator_i;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    if (div_by_zero || div_overflow) begin
                        fast_d  = 1'b1;
                        acc_d   = {{WIDTH{1'b0}}, fast_val};
                        mcand_d = '0;
                        state_d = MD_DONE;
                    end else begin
                        fast_d  = 1'b0;
                        acc_d   = {{WIDTH{1'b0}}, md_is_div(operator_i) ? mag_a : mag_b};
                        mcand_d = md_is_div(operator_i) ? mag_b : mag_a;
                        state_d = MD_CALC;
                    end
                end
            end
            MD_CALC: begin
                acc_d = md_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                if (ready_i) begin
                    state_d = MD_IDLE;
                end
            end
            default: state_d = MD_IDLE;
        endcase
        // A flush in the same cycle as a request drops it, since kill overrides the next state
        if (kill_i) begin
            state_d = MD_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            fast_q    <= fast_d;
        end
    end

    qcv_muldiv_fixup #(
        .WIDTH(WIDTH)
    ) u_fixup (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .bypass_i  (fast_q),
        .result_o  (fix_result)
    );

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign result_o = valid_o ? fix_result : '0;

endmodule

// File: tb/tb_qcv_muldiv.sv
// Scoreboard bench for qcv_muldiv: directed RV32M vectors with hand-computed results,
// latency, backpressure, kill and mid-operation reset checks.
module tb_qcv_muldiv;

    typedef struct {
        logic [31:0] result;
        int          lat;
        int          acceptCycle;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  operator;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    exp_t sbQ[$];
    int   checks;
    int   failures;
    int   cycleCnt;
    int   firstValid;
    bit   seenValid;

    qcv_muldiv #(
        .WIDTH(32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .operator_i  (operator),
        .operand_a_i (operandA),
        .operand_b_i (operandB),
        .kill_i      (kill_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is transferred
    always @(negedge clk) begin
        if (!rst_n) begin
            seenValid = 1'b0;
        end else begin
            if (valid_o && !seenValid) begin
                seenValid  = 1'b1;
                firstValid = cycleCnt;
            end
            if (valid_o && ready_i) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'(valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput(e.name, result_o, e.result);
                    checkOutput({e.name, "_latency"}, 32'(firstValid - e.acceptCycle + 1), 32'(e.lat));
                end
                seenValid = 1'b0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output bit ok);
        int guard;
        guard = 0;
        ok    = 1'b0;
        @(negedge clk);
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            checkOutput("readyTimeout", 32'(ready_o), 32'd1);
            return;
        end
        operator = op;
        operandA = a;
        operandB = b;
        valid_i  = 1'b1;
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
        operator = 3'($urandom);
        operandA = $urandom;
        operandB = $urandom;
        ok       = 1'b1;
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat, input string name);
        bit   ok;
        exp_t e;
        issue(op, a, b, ok);
        if (ok) begin
            e.result      = expRes;
            e.lat         = expLat;
            e.acceptCycle = cycleCnt;
            e.name        = name;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int guard;
        guard = 0;
        while (sbQ.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (sbQ.size() != 0) begin
            checkOutput("drainTimeout", 32'(sbQ.size()), 32'd0);
            sbQ.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          ok;
        bit          bad;
        int          guard;
        logic [31:0] held;
        checks   = 0;
        failures = 0;
        cycleCnt = 0;
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        kill_i   = 1'b0;
        ready_i  = 1'b1;
        operator = 3'd0;
        operandA = '0;
        operandB = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetReady", 32'(ready_o), 32'd1);
        checkOutput("resetValid", 32'(valid_o), 32'd0);
        checkOutput("resetResult", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] multiply latency and ready during CALC");
        applyStimulus(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mulNeg");
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (ready_o !== 1'b0 || valid_o !== 1'b0) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("mulCalcReadyLow", 32'(bad), 32'd0);
        waitDrain();

        $display("[TB] high-word multiplies");
        applyStimulus(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
        waitDrain();
        applyStimulus(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        waitDrain();
        applyStimulus(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu");
        waitDrain();

        $display("[TB] divides");
        applyStimulus(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "divNeg");
        waitDrain();
        applyStimulus(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "remNeg");
        waitDrain();
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
        waitDrain();
        applyStimulus(3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
        waitDrain();

        $display("[TB] divide special cases");
        applyStimulus(3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divByZero");
        waitDrain();
        applyStimulus(3'b111, 32'd5, 32'd0, 32'd5, 1, "remuByZero");
        waitDrain();
        applyStimulus(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "divOverflow");
        waitDrain();
        applyStimulus(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "remOverflow");
        waitDrain();

        $display("[TB] backpressure");
        ready_i = 1'b0;
        applyStimulus(3'b101, 32'd100, 32'd7, 32'd14, 33, "divuStall");
        guard = 0;
        @(negedge clk);
        while (!valid_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("stallValidSeen", 32'(valid_o), 32'd1);
        held = result_o;
        bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b1 || result_o !== held || ready_o !== 1'b0) bad = 1'b1;
        end
        checkOutput("stallStable", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseReady", 32'(ready_o), 32'd1);
        checkOutput("releaseValid", 32'(valid_o), 32'd0);
        waitDrain();

        $display("[TB] kill during CALC");
        issue(3'b000, 32'd12345, 32'd678, ok);
        repeat (4) @(posedge clk);
        @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        checkOutput("killReady", 32'(ready_o), 32'd1);
        checkOutput("killValid", 32'(valid_o), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) bad = 1'b1;
        end
        checkOutput("killNoResult", 32'(bad), 32'd0);

        $display("[TB] kill together with request");
        @(negedge clk);
        operator = 3'b101;
        operandA = 32'd9;
        operandB = 32'd0;
        valid_i  = 1'b1;
        kill_i   = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        kill_i  = 1'b0;
        checkOutput("killReqReady", 32'(ready_o), 32'd1);
        @(negedge clk);
        checkOutput("killReqValid", 32'(valid_o), 32'd0);

        $display("[TB] reset during CALC");
        issue(3'b100, 32'd1000, 32'd3, ok);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstReady", 32'(ready_o), 32'd1);
        checkOutput("rstValid", 32'(valid_o), 32'd0);
        checkOutput("rstResult", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o !== 1'b0) bad = 1'b1;
        end
        checkOutput("rstNoSpurious", 32'(bad), 32'd0);
        applyStimulus(3'b101, 32'd9, 32'd3, 32'd3, 33, "divuAfterReset");
        waitDrain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/qcv_muldiv.md
Name: qcv_muldiv

Overview:
Iterative, parametrised-width multiply/divide unit implementing the RISC-V M-extension operations. It is the multi-cycle companion to the single-cycle combinational ALU in the EX block. The EX block issues one operation through a valid/ready request channel. The block returns one result through a valid/ready response channel after a fixed latency, or early for the divide special cases.

Parameters:
WIDTH, 32, operand/result width in bits (XLEN); must be >= 2.
CNT_W, $clog2(WIDTH), iteration counter width (derived; not overridden).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_ni  input  1  asynchronous active-low reset.
valid_i  input  1  request valid.
ready_o  output  1  unit can accept a request.
operator_i  input  3  operation, equal to RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
operand_a_i  input  WIDTH  rs1 value (multiplicand / dividend).
operand_b_i  input  WIDTH  rs2 value (multiplier / divisor).
kill_i  input  1  synchronous abort (flush) of any request in flight.
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
result_o  output  WIDTH  result; forced to 0 whenever valid_o=0.

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous and active-low. On reset: state IDLE, ready_o=1, valid_o=0, result_o=0, all datapath registers 0.
- State machine: IDLE, CALC, DONE.
  - ready_o=1 only in IDLE.
  - valid_o=1 only in DONE.
- IDLE:
  - A request is accepted when valid_i & ready_o & !kill_i.
  - On accept, latch the operator, operand magnitudes, sign-fix flags and counter = WIDTH-1.
- Fast path, divide ops only:
  - b==0 goes IDLE->DONE directly. Quotient = all ones; remainder = dividend unchanged (DIV/DIVU and REM/REMU respectively).
  - Signed DIV/REM with a = most-negative and b = all ones also goes IDLE->DONE directly. Quotient = most-negative; remainder = 0.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Operands are reduced to magnitudes at accept.
- CALC, one iteration per cycle:
  - Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract (WIDTH-bit remainder plus one guard bit, WIDTH-bit quotient).
  - Counter decrements each cycle. The iteration at counter==0 transitions CALC->DONE.
  - Latency: the accept edge is cycle 0. valid_o rises WIDTH+1 cycles after accept (33 for WIDTH=32). Fast path: valid_o rises 1 cycle after accept.
- DONE: result_o is the registered magnitude result with sign fixup applied from latched flags.
  - MUL: low WIDTH bits of the signed product.
  - MULH, MULHSU, MULHU: high WIDTH bits.
  - Quotient is negated when operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - All arithmetic wraps modulo 2^WIDTH (or 2^(2*WIDTH) for the product).
- Output handshake:
  - valid_o and result_o are held stable while ready_i=0.
  - On valid_o & ready_i the state goes DONE->IDLE, and ready_o=1 in the next cycle. There is no same-cycle re-accept.
- kill_i: in any state, the next state is IDLE with valid_o=0 and no result produced.
  - kill_i in the same cycle as valid_i: the request is dropped (kill wins).
  - kill_i in DONE together with ready_i: the result is discarded; the consumer must ignore it.
- Inputs while busy: valid_i and the operands are ignored outside IDLE. The latched operands must not change if the inputs change mid-operation.
- Reset mid-operation: immediate asynchronous return to IDLE. No spurious valid_o after release.

Decomposition:
- Shared package qcv_pkg:
  - MD operator localparams (MD_MUL..MD_REMU, 3-bit).
  - MD FSM state encoding (IDLE, CALC, DONE).
- Optional sub-module: qcv_muldiv_fixup. It performs the combinational sign correction and high/low result selection, so the datapath can be tested at the unit level. Everything else stays in qcv_muldiv.

Test Plan:
1. MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; valid_o exactly 33 cycles after accept; ready_o low throughout CALC.
2. MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
4. DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. Each with valid_o 1 cycle after accept.
5. Backpressure: ready_i=0 for 10 cycles in DONE -> valid_o and result_o stable, ready_o=0. Then ready_i=1 -> next cycle ready_o=1, valid_o=0.
6. kill_i on CALC cycle 5 -> no valid_o, ready_o=1 next cycle. Separately, rst_ni low mid-CALC -> outputs return to reset values immediately. A following DIVU 9/3 then returns 3.
